// File: rtl/rag_query_ingress_if.sv
// ---------------------------------------------------------------------------
// rag_query_ingress_if
// One AXI-Stream link (tvalid/tready/tdata/tlast). The ingress buffer uses one
// instance on the host side (slave modport) and one on the core side (master
// modport).
//   tvalid  master -> slave  beat valid
//   tready  slave  -> master beat ready
//   tdata   master -> slave  BUS_WIDTH beat data
//   tlast   master -> slave  last beat of a query frame
// ---------------------------------------------------------------------------
interface rag_query_ingress_if #(
   parameter int BUS_WIDTH = 512
);
   logic                 tvalid;
   logic                 tready;
   logic [BUS_WIDTH-1:0] tdata;
   logic                 tlast;

   modport master (output tvalid, output tdata, output tlast, input tready);
   modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/rag_query_ingress.sv
// ---------------------------------------------------------------------------
// rag_query_ingress
// Store-and-forward ingress buffer in front of the RAG-CSD core query port.
// Host beats are written speculatively; a frame becomes visible downstream
// only once its tlast beat has been accepted. Frames longer than MAX_BEATS
// are dropped whole and counted.
//
// Optional build macro RAG_INGRESS_TRUNCATE_EN: oversize frames are cut to
// MAX_BEATS beats (tlast forced on the last kept beat), committed and
// counted; the rest of the frame is consumed and thrown away.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   flush           synchronous clear of all buffered / partial data
//   s_axis          host query stream (slave)
//   m_axis          core query stream (master)
//   frames_pending  committed frames not yet fully read
//   drop_count      oversize-frame events, saturating at 16'hFFFF
// ---------------------------------------------------------------------------
module rag_query_ingress #(
   parameter int BUS_WIDTH = 512,
   parameter int DEPTH     = 16,
   parameter int MAX_BEATS = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   rag_query_ingress_if.slave         s_axis,
   rag_query_ingress_if.master        m_axis,
   output logic [$clog2(DEPTH):0]     frames_pending,
   output logic [15:0]                drop_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;                // extra wrap bit
   localparam int CW = $clog2(MAX_BEATS + 1);

   localparam logic [PW-1:0] PTR_ONE = PW'(1);
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BEATS);
   localparam logic [CW-1:0] CNT_TRN = CW'(MAX_BEATS - 1);

   if (MAX_BEATS > DEPTH || MAX_BEATS < 1) begin : g_bad_max_beats
      $error("rag_query_ingress: MAX_BEATS must be in 1..DEPTH");
   end
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("rag_query_ingress: DEPTH must be a power of two >= 2");
   end

   typedef struct packed {
      logic                 last;
      logic [BUS_WIDTH-1:0] data;
   } entry_t;

   typedef enum logic {ACCEPT = 1'b0, DISCARD = 1'b1} state_t;

   state_t          state, state_nxt;
   entry_t          mem [DEPTH];
   entry_t          rd_entry;
   logic [PW-1:0]   wr_ptr, rd_ptr, commit_ptr, frame_start;
   logic [CW-1:0]   beat_cnt;
   logic            rdy_en;          // holds tready low for the first cycle out of reset
   logic            full;
   logic            oversize_slot;
   logic            wr_fire, rd_fire, rd_last;
   logic            do_write, do_commit, do_drop, wr_last;

   assign full = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

`ifdef RAG_INGRESS_TRUNCATE_EN
   assign oversize_slot = 1'b0;
`else
   // The oversize beat is never written, so it must not wait on full:
   // with MAX_BEATS == DEPTH the buffer could otherwise hold nothing but an
   // uncommitted frame and never drain.
   assign oversize_slot = (beat_cnt == CNT_MAX);
`endif

   // ---------------- read side ----------------
   assign rd_entry      = mem[rd_ptr[AW-1:0]];
   assign m_axis.tvalid = (rd_ptr != commit_ptr);
   assign m_axis.tdata  = m_axis.tvalid ? rd_entry.data : '0;
   assign m_axis.tlast  = m_axis.tvalid ? rd_entry.last : 1'b0;
   assign rd_fire       = m_axis.tvalid && m_axis.tready;
   assign rd_last       = rd_fire && m_axis.tlast;
   assign wr_fire       = s_axis.tvalid && s_axis.tready;

   // ---------------- write-side decode ----------------
   always_comb begin
      do_write  = 1'b0;
      do_commit = 1'b0;
      do_drop   = 1'b0;
      wr_last   = s_axis.tlast;
      if (wr_fire && state == ACCEPT) begin
`ifdef RAG_INGRESS_TRUNCATE_EN
         do_write = 1'b1;
         if (beat_cnt == CNT_TRN) begin
            wr_last   = 1'b1;
            do_commit = 1'b1;
            do_drop   = !s_axis.tlast;
         end else begin
            do_commit = s_axis.tlast;
         end
`else
         if (beat_cnt == CNT_MAX) begin
            do_drop = 1'b1;
         end else begin
            do_write  = 1'b1;
            do_commit = s_axis.tlast;
         end
`endif
      end
   end

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     state <= ACCEPT;
      else if (flush) state <= ACCEPT;
      else            state <= state_nxt;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         ACCEPT:  if (do_drop && !s_axis.tlast)   state_nxt = DISCARD;
         DISCARD: if (wr_fire && s_axis.tlast)    state_nxt = ACCEPT;
         default: state_nxt = ACCEPT;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      s_axis.tready = 1'b0;
      if (rdy_en && !flush) begin
         case (state)
            ACCEPT:  s_axis.tready = !full || oversize_slot;
            DISCARD: s_axis.tready = 1'b1;
            default: s_axis.tready = 1'b0;
         endcase
      end
   end

   // ---------------- pointers and counters ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdy_en         <= 1'b0;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         commit_ptr     <= '0;
         frame_start    <= '0;
         beat_cnt       <= '0;
         frames_pending <= '0;
      end else if (flush) begin
         rdy_en         <= 1'b1;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         commit_ptr     <= '0;
         frame_start    <= '0;
         beat_cnt       <= '0;
         frames_pending <= '0;
      end else begin
         rdy_en <= 1'b1;
         if (do_write) begin
            wr_ptr   <= wr_ptr + PTR_ONE;
            beat_cnt <= beat_cnt + CW'(1);
         end
         if (do_commit) begin
            commit_ptr  <= wr_ptr + PTR_ONE;
            frame_start <= wr_ptr + PTR_ONE;
         end
         if (do_commit || do_drop) beat_cnt <= '0;
         // Whole-frame drop rewinds over the partial frame.
         if (do_drop && !do_commit) wr_ptr <= frame_start;
         if (rd_fire) rd_ptr <= rd_ptr + PTR_ONE;
         case ({do_commit, rd_last})
            2'b10:   frames_pending <= frames_pending + PW'(1);
            2'b01:   frames_pending <= frames_pending - PW'(1);
            default: frames_pending <= frames_pending;
         endcase
      end
   end

   // drop_count survives flush; only reset clears it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         drop_count <= '0;
      else if (do_drop && drop_count != 16'hFFFF)
         drop_count <= drop_count + 16'd1;
   end

   // Storage is not reset; visibility is governed by the pointers.
   always_ff @(posedge clk) begin
      if (do_write) mem[wr_ptr[AW-1:0]] <= '{last: wr_last, data: s_axis.tdata};
   end

endmodule

// File: tb/tb_rag_query_ingress.sv
module tb_rag_query_ingress;
   localparam int W     = 512;
   localparam int DEPTH = 16;
   localparam int MAXB  = 8;
`ifdef RAG_INGRESS_TRUNCATE_EN
   localparam bit TRUNC = 1'b1;
`else
   localparam bit TRUNC = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic [4:0]  frames_pending;
   logic [15:0] drop_count;

   always #5 clk = ~clk;

   rag_query_ingress_if #(.BUS_WIDTH(W)) s_if ();
   rag_query_ingress_if #(.BUS_WIDTH(W)) m_if ();

   rag_query_ingress #(.BUS_WIDTH(W), .DEPTH(DEPTH), .MAX_BEATS(MAXB)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .flush          (flush),
      .s_axis         (s_if),
      .m_axis         (m_if),
      .frames_pending (frames_pending),
      .drop_count     (drop_count)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // behavioural model: frames as queues of {last,data}
   logic [W:0] exp_q [$];
   logic [W:0] part_q [$];
   bit         discarding = 1'b0;
   int         exp_frames = 0;
   int         m_drop = 0;
   int         out_cnt = 0;
   bit         chk_en = 1'b0;
   int         rdy_mode = 0;   // 0 ready, 1 stalled, 2 random

   task automatic chk_b(input string name, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chk_i(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_v(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: timed out", name);
   endtask

   task automatic model_commit();
      foreach (part_q[i]) exp_q.push_back(part_q[i]);
      part_q.delete();
      exp_frames++;
   endtask

   task automatic model_drop();
      if (m_drop < 65535) m_drop++;
   endtask

   task automatic model_in(input logic [W-1:0] d, input logic l);
      if (discarding) begin
         if (l) discarding = 1'b0;
      end else if (TRUNC && part_q.size() == MAXB - 1 && !l) begin
         part_q.push_back({1'b1, d});
         model_commit();
         model_drop();
         discarding = 1'b1;
      end else if (!TRUNC && part_q.size() == MAXB) begin
         part_q.delete();
         model_drop();
         if (!l) discarding = 1'b1;
      end else begin
         part_q.push_back({l, d});
         if (l) model_commit();
      end
   endtask

   // ready driver
   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       m_if.tready = 1'b1;
         1:       m_if.tready = 1'b0;
         default: m_if.tready = 1'($urandom_range(0, 1));
      endcase
   end

   // compare process: outputs vs model every cycle, then advance the model
   always @(negedge clk) begin
      bit exp_rdy;
      int occ;
      if (!rst_n) begin
         exp_q.delete();
         part_q.delete();
         discarding = 1'b0;
         exp_frames = 0;
         m_drop = 0;
      end else if (chk_en) begin
         occ = exp_q.size() + part_q.size();
         if (flush)           exp_rdy = 1'b0;
         else if (discarding) exp_rdy = 1'b1;
         else                 exp_rdy = (occ < DEPTH) || (!TRUNC && part_q.size() == MAXB);
         chk_b("s_tready", s_if.tready, exp_rdy);
         chk_b("m_tvalid", m_if.tvalid, exp_q.size() != 0);
         chk_i("frames_pending", int'(frames_pending), exp_frames);
         chk_i("drop_count", int'(drop_count), m_drop);
         if (exp_q.size() != 0 && m_if.tvalid) begin
            chk_v("m_tdata", m_if.tdata, exp_q[0][W-1:0]);
            chk_b("m_tlast", m_if.tlast, exp_q[0][W]);
            if (m_if.tready) begin
               if (exp_q[0][W]) exp_frames--;
               void'(exp_q.pop_front());
               out_cnt++;
            end
         end
         if (flush) begin
            exp_q.delete();
            part_q.delete();
            discarding = 1'b0;
            exp_frames = 0;
         end else if (s_if.tvalid && s_if.tready) begin
            model_in(s_if.tdata, s_if.tlast);
         end
      end
   end

   function automatic logic [W-1:0] rnd_data();
      logic [W-1:0] r;
      for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom();
      return r;
   endfunction

   task automatic send_beat(input logic [W-1:0] d, input logic l);
      int  n;
      bit  hs;
      n = 0;
      s_if.tvalid = 1'b1;
      s_if.tdata  = d;
      s_if.tlast  = l;
      forever begin
         @(negedge clk);
         hs = s_if.tready;
         @(posedge clk);
         #1;
         if (hs) break;
         n++;
         if (n > 2000) begin
            timeout("send_beat");
            break;
         end
      end
      s_if.tvalid = 1'b0;
   endtask

   task automatic send_frame(input int len, input bit gaps);
      for (int i = 0; i < len; i++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
         send_beat(rnd_data(), i == len - 1);
      end
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || m_if.tvalid) && n < 2000) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 2000) timeout("drain");
      cycles(1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      logic [W-1:0] d;
      s_if.tvalid = 1'b0;
      s_if.tdata  = '0;
      s_if.tlast  = 1'b0;

      // reset state
      #22;
      chk_b("rst_m_tvalid", m_if.tvalid, 1'b0);
      chk_v("rst_m_tdata", m_if.tdata, '0);
      chk_b("rst_m_tlast", m_if.tlast, 1'b0);
      chk_b("rst_s_tready", s_if.tready, 1'b0);
      chk_i("rst_frames_pending", int'(frames_pending), 0);
      chk_i("rst_drop_count", int'(drop_count), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk_b("rel_s_tready_low", s_if.tready, 1'b0);
      @(posedge clk); #1;
      chk_b("rel_s_tready_high", s_if.tready, 1'b1);
      chk_en = 1'b1;

      // 1: single 3-beat frame
      rdy_mode = 0;
      cycles(2);
      send_beat(W'(32'hA), 1'b0);
      chk_b("t1_hidden_b1", m_if.tvalid, 1'b0);
      send_beat(W'(32'hB), 1'b0);
      chk_b("t1_hidden_b2", m_if.tvalid, 1'b0);
      send_beat(W'(32'hC), 1'b1);
      chk_b("t1_visible", m_if.tvalid, 1'b1);
      chk_v("t1_data_a", m_if.tdata, W'(32'hA));
      chk_i("t1_pending_1", int'(frames_pending), 1);
      cycles(1);
      chk_v("t1_data_b", m_if.tdata, W'(32'hB));
      cycles(1);
      chk_v("t1_data_c", m_if.tdata, W'(32'hC));
      chk_b("t1_last_c", m_if.tlast, 1'b1);
      cycles(1);
      chk_b("t1_empty", m_if.tvalid, 1'b0);
      chk_i("t1_pending_0", int'(frames_pending), 0);
      chk_i("t1_drop_0", int'(drop_count), 0);

      // 2: oversize frame followed by a legal frame
      base = out_cnt;
      send_frame(10, 1'b0);
      send_frame(2, 1'b0);
      wait_drain();
      chk_i("t2_drop_1", int'(drop_count), 1);
      chk_i("t2_beats_out", out_cnt - base, TRUNC ? 10 : 2);

      // 3: fill to full with the core stalled
      rdy_mode = 1;
      cycles(2);
      base = out_cnt;
      send_frame(8, 1'b0);
      send_frame(8, 1'b0);
      chk_b("t3_full_tready", s_if.tready, 1'b0);
      chk_i("t3_pending_2", int'(frames_pending), 2);
      rdy_mode = 0;
      cycles(18);
      chk_i("t3_beats_out", out_cnt - base, 16);
      chk_i("t3_pending_0", int'(frames_pending), 0);
      chk_b("t3_tready_back", s_if.tready, 1'b1);

      // 4: wrap-around with random backpressure
      rdy_mode = 2;
      base = out_cnt;
      for (int f = 0; f < 20; f++) send_frame(3, 1'b0);
      wait_drain();
      chk_i("t4_beats_out", out_cnt - base, 60);

      // 5: flush with committed and partial data
      rdy_mode = 1;
      cycles(2);
      send_frame(2, 1'b0);
      send_frame(2, 1'b0);
      for (int i = 0; i < 3; i++) send_beat(rnd_data(), 1'b0);
      chk_i("t5_pending_2", int'(frames_pending), 2);
      s_if.tvalid = 1'b1;
      s_if.tdata  = rnd_data();
      s_if.tlast  = 1'b1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      s_if.tvalid = 1'b0;
      chk_b("t5_tvalid_0", m_if.tvalid, 1'b0);
      chk_i("t5_pending_0", int'(frames_pending), 0);
      chk_i("t5_drop_kept", int'(drop_count), 1);
      rdy_mode = 0;
      base = out_cnt;
      send_frame(2, 1'b0);
      wait_drain();
      chk_i("t5_beats_out", out_cnt - base, 2);

      // random frames, lengths spanning legal and oversize
      rdy_mode = 2;
      for (int f = 0; f < 30; f++) send_frame($urandom_range(1, 12), 1'b1);
      wait_drain();

      // 6: async reset mid-read
      rdy_mode = 0;
      send_frame(4, 1'b0);
      @(posedge clk); #2;
      chk_en = 1'b0;
      rst_n = 1'b0;
      #1;
      chk_b("t6_m_tvalid", m_if.tvalid, 1'b0);
      chk_v("t6_m_tdata", m_if.tdata, '0);
      chk_b("t6_m_tlast", m_if.tlast, 1'b0);
      chk_b("t6_s_tready", s_if.tready, 1'b0);
      chk_i("t6_pending", int'(frames_pending), 0);
      chk_i("t6_drop", int'(drop_count), 0);
      cycles(2);
      rst_n = 1'b1;
      cycles(1);
      chk_en = 1'b1;
      d = rnd_data();
      send_beat(d, 1'b1);
      chk_b("t6_fresh_valid", m_if.tvalid, 1'b1);
      chk_v("t6_fresh_data", m_if.tdata, d);
      chk_b("t6_fresh_last", m_if.tlast, 1'b1);
      wait_drain();
      chk_i("t6_pending_0", int'(frames_pending), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
